// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined Hack-style ALU (alu_pipe).
// Holds the control-word layout and the standard Hack opcode encodings.
package alu_pkg;

    // Control word, MSB first: zx, nx, zy, ny, f, no
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam logic [5:0] ALU_ZERO    = 6'b101010;
    localparam logic [5:0] ALU_ONE     = 6'b111111;
    localparam logic [5:0] ALU_NEG1    = 6'b111010;
    localparam logic [5:0] ALU_X       = 6'b001100;
    localparam logic [5:0] ALU_Y       = 6'b110000;
    localparam logic [5:0] ALU_NOTX    = 6'b001101;
    localparam logic [5:0] ALU_NOTY    = 6'b110001;
    localparam logic [5:0] ALU_NEGX    = 6'b001111;
    localparam logic [5:0] ALU_NEGY    = 6'b110011;
    localparam logic [5:0] ALU_XPLUS1  = 6'b011111;
    localparam logic [5:0] ALU_YPLUS1  = 6'b110111;
    localparam logic [5:0] ALU_XMINUS1 = 6'b001110;
    localparam logic [5:0] ALU_YMINUS1 = 6'b110010;
    localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
    localparam logic [5:0] ALU_XMINUSY = 6'b010011;
    localparam logic [5:0] ALU_YMINUSX = 6'b000111;
    localparam logic [5:0] ALU_XANDY   = 6'b000000;
    localparam logic [5:0] ALU_XORY    = 6'b010101;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit ripple-carry adder built from fulladder cells.
// Carry-in is tied to 0; carry-out is exposed for the optional flag outputs.
module alu_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fulladder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign co_o = carry[WIDTH];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used to build the ripple adder.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides.
// Stage 1 registers the preset operands (zx/nx, zy/ny) and f/no;
// stage 2 registers the result and the zr/ng flags.
// Optional macro ALU_PIPE_FLAGS_EN adds registered carry (co) and
// signed-overflow (ov) outputs of the f=1 add.
//
// Handshake: a beat moves on a side when its valid and ready are both high
// at a rising clk edge. adv2 = !s2_valid || out_ready, adv1 = !s1_valid ||
// adv2, in_ready = adv1 (held low until the first edge after reset release).
// While out_valid && !out_ready the output registers hold.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic             co,
    output logic             ov
`endif
);

    localparam int MSB = WIDTH - 1;

    logic             rdy_q;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] xp_q, xp_d;
    logic [WIDTH-1:0] yp_q, yp_d;
    logic             f_q, no_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic             add_co;
    logic             adv1, adv2, accept, move12;

    // Handshake: each stage may load when it is empty or its successor moves
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 && rdy_q;
        accept   = in_valid && in_ready;
        move12   = s1_valid_q && adv2;
    end

    // Operand preset and stage-1 occupancy
    always_comb begin
        xp_d       = zx ? '0 : x;
        xp_d       = nx ? ~xp_d : xp_d;
        yp_d       = zy ? '0 : y;
        yp_d       = ny ? ~yp_d : yp_d;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i   (xp_q),
        .b_i   (yp_q),
        .sum_o (sum),
        .co_o  (add_co)
    );

    // Compute: add or and, optional final inversion, flags from final value
    always_comb begin
        r     = f_q ? sum : (xp_q & yp_q);
        out_d = no_q ? ~r : r;
        zr_d  = (out_d == '0);
        ng_d  = out_d[MSB];
    end

    // in_ready is suppressed until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Stage 1 registers; operands are sampled only on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            xp_q       <= '0;
            yp_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                xp_q <= xp_d;
                yp_q <= yp_d;
                f_q  <= f;
                no_q <= no;
            end
        end
    end

    // Stage 2 registers; result holds unless stage 1 moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
            end
            if (move12) begin
                out_q <= out_d;
                zr_q  <= zr_d;
                ng_q  <= ng_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

`ifdef ALU_PIPE_FLAGS_EN
    logic co_q, co_d;
    logic ov_q, ov_d;

    // Add flags are zero for the AND function and ignore the no inversion
    always_comb begin
        co_d = f_q & add_co;
        ov_d = f_q & (xp_q[MSB] == yp_q[MSB]) & (sum[MSB] != xp_q[MSB]);
    end

    // Flag registers load alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (move12) begin
            co_q <= co_d;
            ov_q <= ov_d;
        end
    end

    assign co = co_q;
    assign ov = ov_q;
`else
    logic carry_unused;
    assign carry_unused = add_co;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=16): directed vectors with hand-computed
// results pushed into an expected queue; a negedge monitor pops and
// compares on every output transfer and checks stability under stall.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;
`ifdef ALU_PIPE_FLAGS_EN
  localparam int EW = W + 4;
`else
  localparam int EW = W + 2;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [5:0]   ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr;
  logic         ng;
`ifdef ALU_PIPE_FLAGS_EN
  logic         co;
  logic         ov;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;
  bit            hold_pend;
  logic [EW-1:0] hold_val;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .zx        (ctrl[5]),
    .nx        (ctrl[4]),
    .zy        (ctrl[3]),
    .ny        (ctrl[2]),
    .f         (ctrl[1]),
    .no        (ctrl[0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .co        (co),
    .ov        (ov)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [W-1:0] o, input logic z,
                                       input logic n, input logic c, input logic v);
`ifdef ALU_PIPE_FLAGS_EN
    return {o, z, n, c, v};
`else
    logic unused_cv;
    unused_cv = c ^ v;
    return {o, z, n};
`endif
  endfunction

  function automatic logic [EW-1:0] got_now();
`ifdef ALU_PIPE_FLAGS_EN
    return mk(out, zr, ng, co, ov);
`else
    return mk(out, zr, ng, 1'b0, 1'b0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver: present a beat and wait (bounded) for it to be accepted
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic [5:0] cv, input logic [EW-1:0] e);
    bit acc;
    acc      = 1'b0;
    x        = xv;
    y        = yv;
    ctrl     = cv;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back(e);
    else chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // isolated beat: out_valid must appear exactly two cycles after acceptance
  task automatic send_lat(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [5:0] cv, input logic [EW-1:0] e);
    send(xv, yv, cv, e);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat_t1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_lat_t2"}, {31'd0, out_valid}, 32'd1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [EW-1:0] got;
      got = got_now();
      if (hold_pend) chk_w("hold_stable", got, hold_val);
      if (out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk_w("result", got, e);
        end
      end else begin
        hold_pend = 1'b1;
        hold_val  = got;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    hold_pend = 1'b0;
    hold_val  = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    x         = 16'h1234;
    y         = 16'h0001;
    ctrl      = ALU_XPLUSY;
    out_ready = 1'b1;

    // reset state with in_valid held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_zr", {31'd0, zr}, 32'd0);
    chk("rst_ng", {31'd0, ng}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("release_in_ready_0", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_in_ready_1", {31'd0, in_ready}, 32'd1);

    // add with exact latency
    send_lat("add", 16'd5, 16'd3, ALU_XPLUSY, mk(16'd8, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(2);

    // back-to-back function mix
    send(16'd3, 16'd5, ALU_XMINUSY, mk(16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0));
    send(16'h1234, 16'hABCD, ALU_ZERO, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    send(16'hF0F0, 16'hFF00, ALU_XANDY, mk(16'hF000, 1'b0, 1'b1, 1'b0, 1'b0));
    send(16'h00F0, 16'h0F00, ALU_XORY, mk(16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(16'h5555, 16'hAAAA, ALU_NEG1, mk(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0));
    send(16'h5555, 16'hAAAA, ALU_ONE, mk(16'h0001, 1'b0, 1'b0, 1'b1, 1'b0));
    idle(4);

    // backpressure: out_ready low for three cycles mid-stream
    fork
      begin
        send(16'd1, 16'd1, ALU_XPLUSY, mk(16'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'd2, 16'd2, ALU_XPLUSY, mk(16'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'd3, 16'd3, ALU_XPLUSY, mk(16'd6, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'd4, 16'd4, ALU_XPLUSY, mk(16'd8, 1'b0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // wrap-around and flags
    send(16'h7FFF, 16'h0001, ALU_XPLUSY, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
    send(16'hFFFF, 16'h0001, ALU_XPLUSY, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(4);

    // reset with two beats in flight: nothing may transfer
    out_ready = 1'b0;
    send(16'd9, 16'd9, ALU_XPLUSY, mk(16'd18, 1'b0, 1'b0, 1'b0, 1'b0));
    send(16'd10, 16'd10, ALU_XPLUSY, mk(16'd20, 1'b0, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", {16'd0, out}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_lat("post_rst", 16'd7, 16'd0, ALU_XPLUSY, mk(16'd7, 1'b0, 1'b0, 1'b0, 1'b0));

    // drain the scoreboard (bounded)
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
